// File: rtl/permute_pkg.sv
// Shared types and sizing for the permute datapath.
// One state is NUM_SLICES slices of SLICE_W bits each.
package permute_pkg;

    localparam int SLICE_W    = 25;
    localparam int NUM_SLICES = 64;
    localparam int ADDR_W     = $clog2(NUM_SLICES);
    localparam int IDX_W      = 10;

    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [ADDR_W-1:0]  slice_addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DUMP   = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/slice_buffer.sv
// Holds one permutation state.
// Synchronous write port, combinational read port.
module slice_buffer
    import permute_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [SLICE_W-1:0]  wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [SLICE_W-1:0]  rdata
);

    slice_t mem [NUM_SLICES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/slice_output_sequencer.sv
// Buffers a permutation state and streams it to the file writer,
// one slice per cycle, after each done pulse.
module slice_output_sequencer
    import permute_pkg::*;
#(
    parameter int IDX_W = permute_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_we,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [SLICE_W-1:0]  in_data,
    input  logic                done,
    output logic                write_file,
    output logic [IDX_W-1:0]    file_index,
    output logic [SLICE_W-1:0]  data_out,
    output logic                busy,
    output logic                dump_done,
    output logic                overrun
);

    localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(NUM_SLICES);

    seq_state_t       state;
    logic [ADDR_W:0]  cnt;
    logic             buf_we;
    slice_t           rd_data;

    // The buffer only accepts writes while no dump is in flight.
    assign buf_we = in_we && (state == IDLE);

    slice_buffer u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (in_addr),
        .wdata (in_data),
        .raddr (cnt[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            write_file <= 1'b0;
            file_index <= '0;
            data_out   <= '0;
            busy       <= 1'b0;
            dump_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            if ((state != IDLE) && (in_we || done)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (done) begin
                        state <= DUMP;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                DUMP: begin
                    if (cnt == CNT_END) begin
                        write_file <= 1'b0;
                        dump_done  <= 1'b1;
                        file_index <= file_index + 1'b1;
                        state      <= FINISH;
                    end else begin
                        write_file <= 1'b1;
                        data_out   <= rd_data;
                        cnt        <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/slice_output_sequencer.md
Name: slice_output_sequencer

Overview:
- Upstream feeder of the file-writer stage in the permute datapath.
- Buffers one full permutation state of 64 slices × 25 bits, written by the permutation core. On `done`, streams the slices to the writer, one per cycle.
- Supplies `write_file`, `file_index` and `data_out`. `file_index` counts completed states, so each state lands in its own `output_<n>.txt`.

Parameters:
- SLICE_W, 25, bits per slice (5×5 plane).
- NUM_SLICES, 64, slices per state (lane depth).
- IDX_W, 10, width of `file_index`.
- ADDR_W, 6, slice address width; must equal clog2(NUM_SLICES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_we  input  1  write strobe from the permutation core.
- in_addr  input  ADDR_W  slice address for `in_we`.
- in_data  input  SLICE_W  slice value for `in_we`.
- done  input  1  single-cycle pulse: state complete, start dump.
- write_file  output  1  writer strobe, one slice per high cycle.
- file_index  output  IDX_W  index of the state being dumped.
- data_out  output  SLICE_W  slice presented to the writer.
- busy  output  1  high from the `done` acceptance until FINISH ends.
- dump_done  output  1  single-cycle pulse after the last slice.
- overrun  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous, active-high.
- Reset values:
  - `write_file`, `busy`, `dump_done`, `overrun` = 0.
  - `file_index` = 0, `data_out` = 0.
  - State = IDLE, slice counter = 0.
- Buffer contents are not reset. The bench must not depend on them before the first write.

States:
- IDLE:
  - `in_we` writes `buf[in_addr] <= in_data` at the clock edge.
  - `done` sampled high at edge E0 → DUMP, counter = 0, `busy` = 1 from E0.
- DUMP:
  - Outputs are registered. After edge E(k+1), k = 0..NUM_SLICES-1: `write_file` = 1 and `data_out` = buf[k].
  - The writer therefore sees 64 consecutive high cycles, slice 0 first, with no gaps.
  - After the edge that presents slice NUM_SLICES-1, the next edge moves to FINISH.
- FINISH (one cycle, after edge E(NUM_SLICES+1)):
  - `write_file` = 0 and `dump_done` = 1.
  - `file_index` increments at this same edge (modulo 2^IDX_W, so 1023 wraps to 0).
  - Next edge → IDLE, `busy` = 0, `dump_done` = 0.

Output stability and timing:
- `file_index` is stable throughout every `write_file`-high cycle of a dump.
- `data_out` holds the last slice after DUMP until the next dump.
- Latency: `done` at E0 → first `write_file` cycle follows E1. `dump_done` follows E65 with defaults.

Boundary cases:
- `in_we` and `done` in the same IDLE cycle: the write is committed at E0 and is visible in the dump.
- `in_we` while `busy`: the write is ignored (the buffer is unchanged) and `overrun` sets.
- `done` while `busy`: ignored and `overrun` sets.
- `overrun` is cleared only by `rst`.
- Reset mid-dump:
  - Every output returns to its reset value immediately (asynchronous).
  - `file_index` returns to 0 and the remaining slices are not emitted.
  - The next `done` after reset starts a fresh dump at slice 0.
- `in_addr` is always within range (NUM_SLICES is a power of two), so there is no bounds check.

Decomposition:
- Shared package `permute_pkg`:
  - Constants SLICE_W, NUM_SLICES, ADDR_W, IDX_W.
  - Typedef `slice_t` (logic [SLICE_W-1:0]) and `slice_addr_t`.
  - Enum `seq_state_t` {IDLE, DUMP, FINISH}.
- One sub-module, `slice_buffer`: a 1W1R register array, NUM_SLICES × SLICE_W, with synchronous write and combinational read. The sequencer FSM, counter and output registers live in the top module.

Test Plan:
- Basic dump: after reset, write buf[k] = k·0x1_1111 & 0x1FF_FFFF for k = 0..63, then pulse `done`.
  - Expect exactly 64 `write_file` cycles, beginning the cycle after E1.
  - Expect `data_out` = those values in order 0..63, `file_index` = 0 throughout.
  - Expect `dump_done` one cycle later, then `file_index` = 1.
- Back-to-back states: three load/dump sequences with distinct patterns (all 0, 0x1FF_FFFF, alternating 0x0AA_AAAA/0x155_5555).
  - Expect `file_index` values 0, 1, 2 during the dumps and final value 3.
- Collisions:
  - `in_we` to address 5 with 0x123_4567 in the same cycle as `done` → slice 5 out = 0x123_4567.
  - `in_we` during DUMP → buffer unchanged on the next dump, `overrun` = 1.
  - Second `done` during DUMP → no extra writes, `overrun` = 1.
- Reset mid-dump: assert `rst` asynchronously after slice 20 is emitted.
  - Expect `write_file`, `busy`, `file_index` = 0 without waiting for a clock edge.
  - Expect a fresh `done` to yield 64 slices starting at slice 0, with `file_index` = 0.
- Index wrap: force 1024 dumps (or set IDX_W = 2 and run 5 dumps).
  - Expect `file_index` sequence 0, 1, 2, 3, 0.
